// File: rtl/registrador_pkg.sv
// Shared constants and helpers for the registrador serial-in shift register.
package registrador_pkg;

  localparam int REG_WIDTH_DEFAULT = 1;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/registrador_if.sv
// Signal bundle for one registrador instance: driver side and register side.
interface registrador_if
  import registrador_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) (
  input logic clk
);

  logic                      rst;
  logic                      entrada;
  logic                      load;
  logic                      saida;
  logic [WIDTH-1:0]          q;
  logic                      full;
  logic [cnt_w(WIDTH)-1:0]   count;

  modport master (
    input  clk,
    output rst,
    output entrada,
    output load,
    input  saida,
    input  q,
    input  full,
    input  count
  );

  modport slave (
    input  clk,
    input  rst,
    input  entrada,
    input  load,
    output saida,
    output q,
    output full,
    output count
  );

endinterface

// File: rtl/registrador.sv
// Serial-in shift register with parallel view and a saturating fill counter.
module registrador
  import registrador_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic                    entrada,
  input  logic                    clk,
  input  logic                    load,
  output logic                    saida,
  input  logic                    rst,
  output logic [WIDTH-1:0]        q,
  output logic                    full,
  output logic [cnt_w(WIDTH)-1:0] count
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;

  // Shift-by-one then OR keeps WIDTH=1 legal without a zero-width slice.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (q_q << 1) | WIDTH'(entrada);
    end
  end

  always_comb begin
    count_d = count_q;
    full_d  = full_q;
    if (load && !full_q) begin
      count_d = count_q + CW'(1);
      full_d  = (count_d == CW'(WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign q     = q_q;
  assign saida = q_q[WIDTH-1];
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: tb/tb_registrador.sv
// Directed bench for registrador at WIDTH 1, 4 and 8.
module tb_registrador;
  import registrador_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  registrador_if #(.WIDTH(1)) a1 (.clk(clk));
  registrador_if #(.WIDTH(4)) a4 (.clk(clk));
  registrador_if #(.WIDTH(8)) a8 (.clk(clk));

  registrador #(.WIDTH(1)) u1 (
    .entrada(a1.entrada), .clk(clk), .load(a1.load),
    .saida(a1.saida), .rst(a1.rst), .q(a1.q),
    .full(a1.full), .count(a1.count)
  );

  registrador #(.WIDTH(4)) u4 (
    .entrada(a4.entrada), .clk(clk), .load(a4.load),
    .saida(a4.saida), .rst(a4.rst), .q(a4.q),
    .full(a4.full), .count(a4.count)
  );

  registrador #(.WIDTH(8)) u8 (
    .entrada(a8.entrada), .clk(clk), .load(a8.load),
    .saida(a8.saida), .rst(a8.rst), .q(a8.q),
    .full(a8.full), .count(a8.count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat8;
  logic [3:0] pat4;

  initial begin
    a1.rst = 1'b1; a1.load = 1'b0; a1.entrada = 1'b0;
    a4.rst = 1'b1; a4.load = 1'b0; a4.entrada = 1'b0;
    a8.rst = 1'b1; a8.load = 1'b0; a8.entrada = 1'b0;
    #2;
    tick();
    a1.rst = 1'b0; a4.rst = 1'b0; a8.rst = 1'b0;

    chk("rst_q1", 64'(a1.q), 64'h0);
    chk("rst_cnt1", 64'(a1.count), 64'h0);
    chk("rst_full1", 64'(a1.full), 64'h0);
    chk("rst_q4", 64'(a4.q), 64'h0);
    chk("rst_saida4", 64'(a4.saida), 64'h0);
    chk("rst_cnt8", 64'(a8.count), 64'h0);
    chk("rst_full8", 64'(a8.full), 64'h0);

    // WIDTH=1
    a1.entrada = 1'b1; a1.load = 1'b1;
    tick();
    chk("w1_saida", 64'(a1.saida), 64'h1);
    chk("w1_full", 64'(a1.full), 64'h1);
    chk("w1_cnt", 64'(a1.count), 64'h1);
    a1.entrada = 1'b0; a1.load = 1'b0;
    tick();
    chk("w1_hold", 64'(a1.saida), 64'h1);
    a1.load = 1'b1;
    tick();
    chk("w1_load0", 64'(a1.saida), 64'h0);
    chk("w1_cnt_sat", 64'(a1.count), 64'h1);
    chk("w1_full_sat", 64'(a1.full), 64'h1);
    a1.load = 1'b0;

    // WIDTH=4 fill 1,0,1,1
    pat4 = 4'b1011;
    a4.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a4.entrada = pat4[3-i];
      tick();
      chk("w4_cnt", 64'(a4.count), 64'(i + 1));
      chk("w4_full", 64'(a4.full), 64'(i == 3));
    end
    chk("w4_q", 64'(a4.q), 64'hB);
    chk("w4_saida", 64'(a4.saida), 64'h1);
    a4.entrada = 1'b0;
    tick();
    chk("w4_q_post", 64'(a4.q), 64'h6);
    chk("w4_cnt_sat", 64'(a4.count), 64'h4);
    chk("w4_full_sat", 64'(a4.full), 64'h1);
    chk("w4_saida_post", 64'(a4.saida), 64'h0);

    // rst mid-fill, rst beats load
    a4.rst = 1'b1; a4.load = 1'b0;
    tick();
    a4.rst = 1'b0; a4.load = 1'b1; a4.entrada = 1'b1;
    tick();
    tick();
    chk("w4_mid_q", 64'(a4.q), 64'h3);
    chk("w4_mid_cnt", 64'(a4.count), 64'h2);
    a4.rst = 1'b1;
    tick();
    chk("w4_rl_q", 64'(a4.q), 64'h0);
    chk("w4_rl_cnt", 64'(a4.count), 64'h0);
    chk("w4_rl_full", 64'(a4.full), 64'h0);
    a4.rst = 1'b0;
    tick();
    chk("w4_restart_q", 64'(a4.q), 64'h1);
    chk("w4_restart_cnt", 64'(a4.count), 64'h1);
    a4.load = 1'b0; a4.entrada = 1'b0;
    tick();
    chk("w4_hold_q", 64'(a4.q), 64'h1);
    chk("w4_hold_cnt", 64'(a4.count), 64'h1);

    // WIDTH=8 alternate load, junk on idle edges
    pat8 = 8'hCA;
    for (int i = 0; i < 16; i++) begin
      a8.load = (i % 2 == 0);
      a8.entrada = a8.load ? pat8[7 - i/2] : ~pat8[7 - i/2];
      tick();
      if (i == 7) begin
        chk("w8_mid_cnt", 64'(a8.count), 64'h4);
        chk("w8_mid_full", 64'(a8.full), 64'h0);
        chk("w8_mid_q", 64'(a8.q), 64'hC);
      end
    end
    a8.load = 1'b0;
    chk("w8_cnt", 64'(a8.count), 64'h8);
    chk("w8_full", 64'(a8.full), 64'h1);
    chk("w8_q", 64'(a8.q), 64'hCA);
    chk("w8_saida", 64'(a8.saida), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
